// File: rtl/mult_pkg.sv
// Shared constants and types for the pipelined multiplier.
`timescale 1ns/1ps
package mult_pkg;

    // Operand width used when the instantiating code does not override it.
    localparam int MULT_DEFAULT_WIDTH = 16;

    // Rising edges from operand sampling to the product appearing on P.
    localparam int MULT_LATENCY = 3;

    // Product of two half-width operands at the default width (W/2 x W/2 -> W bits).
    typedef logic [MULT_DEFAULT_WIDTH-1:0] mult_half_prod_t;

endpackage

// File: rtl/mult_half.sv
// Unsigned half-width combinational multiplier: HW x HW -> 2*HW bits.
`timescale 1ns/1ps
module mult_half #(
    parameter int HW = 8
) (
    input  logic [HW-1:0]   a,
    input  logic [HW-1:0]   b,
    output logic [2*HW-1:0] p
);

    // Both operands are zero-extended so the full product width is kept.
    always_comb begin
        p = {{HW{1'b0}}, a} * {{HW{1'b0}}, b};
    end

endmodule

// File: rtl/mult.sv
// Three-stage pipelined WIDTH x WIDTH multiplier with a full 2*WIDTH-bit product.
// Stage 1 registers the operands (magnitudes and sign in signed builds),
// stage 2 registers four half-width partial products, stage 3 sums them into P.
// Define MULT_SIGNED_EN for two's-complement operands and product; without it
// the multiplier is unsigned and carries no sign logic.
// WIDTH must be even and at least 4.
`timescale 1ns/1ps
module mult
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   P
);

    localparam int H = WIDTH / 2;

    // Operand values presented to stage 1 (magnitudes in signed builds).
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;

    // Stage 1 registers.
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;

    // Partial products from the half-width multipliers.
    logic [WIDTH-1:0]   ll_s;
    logic [WIDTH-1:0]   lh_s;
    logic [WIDTH-1:0]   hl_s;
    logic [WIDTH-1:0]   hh_s;

    // Stage 2 registers.
    logic [WIDTH-1:0]   ll_r;
    logic [WIDTH-1:0]   lh_r;
    logic [WIDTH-1:0]   hl_r;
    logic [WIDTH-1:0]   hh_r;

    // Stage 3 arithmetic: the cross-term sum keeps its carry bit.
    logic [WIDTH:0]     mid_s;
    logic [2*WIDTH-1:0] sum_s;
    logic [2*WIDTH-1:0] res_s;

`ifdef MULT_SIGNED_EN
    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

    logic sign_s;
    logic sign1_r;
    logic sign2_r;

    // Split signed operands into magnitude and result sign; the most negative
    // value maps onto itself, which is its correct unsigned magnitude.
    always_comb begin
        sign_s = A[WIDTH-1] ^ B[WIDTH-1];
        if (A[WIDTH-1]) begin
            a_mag_s = (~A) + ONE_W;
        end else begin
            a_mag_s = A;
        end
        if (B[WIDTH-1]) begin
            b_mag_s = (~B) + ONE_W;
        end else begin
            b_mag_s = B;
        end
    end

    // Carry the result sign alongside the data through stages 1 and 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            sign1_r <= 1'b0;
            sign2_r <= 1'b0;
        end else begin
            sign1_r <= sign_s;
            sign2_r <= sign1_r;
        end
    end
`else
    // Unsigned build: operands pass straight into stage 1.
    always_comb begin
        a_mag_s = A;
        b_mag_s = B;
    end
`endif

    // Stage 1: capture operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r <= {WIDTH{1'b0}};
            b_r <= {WIDTH{1'b0}};
        end else begin
            a_r <= a_mag_s;
            b_r <= b_mag_s;
        end
    end

    mult_half #(.HW(H)) u_ll (.a(a_r[H-1:0]),     .b(b_r[H-1:0]),     .p(ll_s));
    mult_half #(.HW(H)) u_lh (.a(a_r[H-1:0]),     .b(b_r[WIDTH-1:H]), .p(lh_s));
    mult_half #(.HW(H)) u_hl (.a(a_r[WIDTH-1:H]), .b(b_r[H-1:0]),     .p(hl_s));
    mult_half #(.HW(H)) u_hh (.a(a_r[WIDTH-1:H]), .b(b_r[WIDTH-1:H]), .p(hh_s));

    // Stage 2: capture the four partial products.
    always_ff @(posedge clk) begin
        if (rst) begin
            ll_r <= {WIDTH{1'b0}};
            lh_r <= {WIDTH{1'b0}};
            hl_r <= {WIDTH{1'b0}};
            hh_r <= {WIDTH{1'b0}};
        end else begin
            ll_r <= ll_s;
            lh_r <= lh_s;
            hl_r <= hl_s;
            hh_r <= hh_s;
        end
    end

    // Recombine partial products; the true product always fits in 2*WIDTH bits.
    always_comb begin
        mid_s = {1'b0, lh_r} + {1'b0, hl_r};
        sum_s = {{WIDTH{1'b0}}, ll_r}
              + ({{(WIDTH-1){1'b0}}, mid_s} << H)
              + {hh_r, {WIDTH{1'b0}}};
`ifdef MULT_SIGNED_EN
        if (sign2_r) begin
            res_s = (~sum_s) + ONE_2W;
        end else begin
            res_s = sum_s;
        end
`else
        res_s = sum_s;
`endif
    end

    // Stage 3: registered product output.
    always_ff @(posedge clk) begin
        if (rst) begin
            P <= {(2*WIDTH){1'b0}};
        end else begin
            P <= res_s;
        end
    end

endmodule

// File: tb/tb_mult.sv
// Self-checking bench for mult (WIDTH=16). Expected products come from a
// history of sampled operands and reset flags: P after edge n is zero if reset
// was high at edge n, n-1 or n-2, otherwise the product of the pair sampled at n-2.
`timescale 1ns/1ps
module tb_mult;

    localparam int W = 16;

    logic            clk;
    logic            rst;
    logic [W-1:0]    A;
    logic [W-1:0]    B;
    logic [2*W-1:0]  P;

    int n_assert;
    int n_fail;

    logic [W-1:0] ha[$];
    logic [W-1:0] hb[$];
    bit           hr[$];

    mult #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .P   (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
        longint x;
        longint y;
`ifdef MULT_SIGNED_EN
        x = longint'($signed(a));
        y = longint'($signed(b));
`else
        x = longint'(a);
        y = longint'(b);
`endif
        prod = 32'(x * y);
    endfunction

    function automatic logic [2*W-1:0] model_p();
        int n;
        n = hr.size() - 1;
        if (n < 2) return '0;
        if (hr[n] || hr[n-1] || hr[n-2]) return '0;
        return prod(ha[n-2], hb[n-2]);
    endfunction

    task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Glitch the operands mid-cycle, settle on the real values, clock, then check.
    task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input bit r);
        A = W'($urandom);
        B = W'($urandom);
        #2;
        A = a;
        B = b;
        rst = r;
        @(posedge clk);
        ha.push_back(a);
        hb.push_back(b);
        hr.push_back(r);
        #1;
        chk("model", P, model_p());
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        A = '0;
        B = '0;

        // Reset held for two edges with 5x5 on the inputs.
        step(16'd5, 16'd5, 1'b1);
        chk("rst_hold0", P, 32'd0);
        step(16'd5, 16'd5, 1'b1);
        chk("rst_hold1", P, 32'd0);
        step(16'd5, 16'd5, 1'b0);
        chk("rst_rel0", P, 32'd0);
        step(16'd5, 16'd5, 1'b0);
        chk("rst_rel1", P, 32'd0);
        step(16'd1, 16'd1, 1'b0);
        chk("rst_first", P, 32'd25);

        // Latency and back-to-back throughput, then boundary pairs.
        step(16'd2, 16'd3, 1'b0);
        chk("lat_early0", {31'd0, P === 32'd6}, 32'd0);
        step(16'd4, 16'd5, 1'b0);
        chk("lat_early1", {31'd0, P === 32'd6}, 32'd0);
        step(16'd6, 16'd7, 1'b0);
        chk("lat_thr0", P, 32'd6);
        step(16'h0000, 16'hFFFF, 1'b0);
        chk("thr1", P, 32'd20);
        step(16'hFFFF, 16'hFFFF, 1'b0);
        chk("thr2", P, 32'd42);
        step(16'hFFFE, 16'd3, 1'b0);
        chk("zero", P, 32'd0);
        step(16'h8000, 16'h8000, 1'b0);
`ifdef MULT_SIGNED_EN
        chk("max_sq", P, 32'h0000_0001);
`else
        chk("max_sq", P, 32'hFFFE_0001);
`endif
        step(16'd0, 16'd0, 1'b0);
`ifdef MULT_SIGNED_EN
        chk("sign_mix", P, 32'hFFFF_FFFA);
`else
        chk("sign_mix", P, 32'h0002_FFFA);
`endif
        step(16'd0, 16'd0, 1'b0);
        chk("min_sq", P, 32'h4000_0000);

        // Reset pulse right after sampling 7x9: 63 must never surface.
        step(16'd7, 16'd9, 1'b0);
        step(16'd7, 16'd9, 1'b1);
        chk("mid_rst0", {31'd0, P === 32'd63}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(16'd1, 16'd2, 1'b0);
            chk("mid_rst", {31'd0, P === 32'd63}, 32'd0);
        end

        // Random operands with occasional resets, checked against the model.
        for (int i = 0; i < 300; i++) begin
            step(W'($urandom), W'($urandom), ($urandom_range(0, 31) == 0));
        end

        // Drain the pipeline.
        for (int i = 0; i < 3; i++) begin
            step(16'd0, 16'd0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
